// File: rtl/bcd_pkg.sv
// Shared BCD types and constants for the BCD down-counter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_ZERO = 4'd0;

    // Out-of-range load digits are stored as the largest legal value.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD decade: load with clamping, decrement on borrow_in, 0 -> 9 wrap.
module bcd_down_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  bcd_digit_t din,
    input  logic       borrow_in,
    output bcd_digit_t q_digit,
    output logic       borrow_out
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_digit <= BCD_ZERO;
        end else if (load) begin
            q_digit <= bcd_clamp(din);
        end else if (borrow_in) begin
            q_digit <= (q_digit == BCD_ZERO) ? BCD_MAX : q_digit - 4'd1;
        end
    end

    assign borrow_out = borrow_in & (q_digit == BCD_ZERO);

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-decade BCD down-counter with load, underflow pulse and load-error pulse.
// Define BCD_DOWN_COUNTER_SATURATE_EN to hold at zero instead of wrapping to all nines.
module bcd_down_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    output logic [4*DIGITS-1:0]   q,
    output logic                  zero,
    output logic                  borrow,
    output logic                  load_err
);

    logic [DIGITS:0] chain;
    logic            count_req;
    logic            borrow_next;
    logic            din_bad;

    assign zero = (q == '0);

    always_comb begin
        din_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (din[4*i +: 4] > BCD_MAX) din_bad = 1'b1;
        end
    end

`ifdef BCD_DOWN_COUNTER_SATURATE_EN
    logic armed;

    assign count_req   = en & ~zero;
    assign borrow_next = ~load & en & zero & armed;

    // Only one borrow per visit to zero; a load of a nonzero value re-arms.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed <= 1'b1;
        end else if (load) begin
            if (|din) armed <= 1'b1;
        end else if (en & zero) begin
            armed <= 1'b0;
        end
    end
`else
    assign count_req   = en;
    assign borrow_next = ~load & en & zero;
`endif

    assign chain[0] = count_req;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_down_digit u_digit (
            .clk        (clk),
            .rst        (rst),
            .load       (load),
            .din        (din[4*g +: 4]),
            .borrow_in  (chain[g]),
            .q_digit    (q[4*g +: 4]),
            .borrow_out (chain[g+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            borrow   <= 1'b0;
            load_err <= 1'b0;
        end else begin
            borrow   <= borrow_next;
            load_err <= load & din_bad;
        end
    end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed-vector bench for bcd_down_counter (DIGITS=2), both underflow modes.
module tb_bcd_down_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [7:0] din;
    logic [7:0] q;
    logic       zero;
    logic       borrow;
    logic       load_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic       load;
        logic       en;
        logic [7:0] din;
        logic [7:0] q;
        logic       zero;
        logic       borrow;
        logic       load_err;
    } vec_t;

    vec_t vecs[$];

    bcd_down_counter #(.DIGITS(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .din      (din),
        .q        (q),
        .zero     (zero),
        .borrow   (borrow),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input string nm, input logic r, input logic l, input logic e,
                       input logic [7:0] d, input logic [7:0] eq, input logic ez,
                       input logic eb, input logic ele);
        vec_t v;
        v.name = nm; v.rst = r; v.load = l; v.en = e; v.din = d;
        v.q = eq; v.zero = ez; v.borrow = eb; v.load_err = ele;
        vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic l, input logic e, input logic [7:0] d);
        @(negedge clk);
        rst = r; load = l; en = e; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic check_all(input string nm, input logic [7:0] eq, input logic ez,
                             input logic eb, input logic ele);
        check({nm, ".q"}, q, eq);
        check({nm, ".zero"}, {7'd0, zero}, {7'd0, ez});
        check({nm, ".borrow"}, {7'd0, borrow}, {7'd0, eb});
        check({nm, ".load_err"}, {7'd0, load_err}, {7'd0, ele});
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    initial begin
        int  val;
        logic armed;
        logic exp_b;
        logic sat;

        rst = 1'b1; load = 1'b0; en = 1'b0; din = 8'h00;

`ifdef BCD_DOWN_COUNTER_SATURATE_EN
        sat = 1'b1;
        add("rst",        1, 0, 0, 8'h00, 8'h00, 1, 0, 0);
        add("sat_first",  0, 0, 1, 8'h00, 8'h00, 1, 1, 0);
        add("sat_hold",   0, 0, 1, 8'h00, 8'h00, 1, 0, 0);
        add("sat_ld01",   0, 1, 0, 8'h01, 8'h01, 0, 0, 0);
        add("sat_to0",    0, 0, 1, 8'h00, 8'h00, 1, 0, 0);
        add("sat_pulse",  0, 0, 1, 8'h00, 8'h00, 1, 1, 0);
        add("sat_again",  0, 0, 1, 8'h00, 8'h00, 1, 0, 0);
        add("sat_ld00",   0, 1, 0, 8'h00, 8'h00, 1, 0, 0);
        add("sat_noarm",  0, 0, 1, 8'h00, 8'h00, 1, 0, 0);
`else
        sat = 1'b0;
        add("rst",        1, 0, 0, 8'h00, 8'h00, 1, 0, 0);
        add("uf99",       0, 0, 1, 8'h00, 8'h99, 0, 1, 0);
        add("cnt98",      0, 0, 1, 8'h00, 8'h98, 0, 0, 0);
        add("cnt97",      0, 0, 1, 8'h00, 8'h97, 0, 0, 0);
        add("ld01",       0, 1, 0, 8'h01, 8'h01, 0, 0, 0);
        add("to00",       0, 0, 1, 8'h00, 8'h00, 1, 0, 0);
        add("uf_again",   0, 0, 1, 8'h00, 8'h99, 0, 1, 0);
`endif
        add("hold",       0, 0, 0, 8'h55, vecs[$].q, vecs[$].zero, 0, 0);
        add("ld10",       0, 1, 0, 8'h10, 8'h10, 0, 0, 0);
        add("cnt09",      0, 0, 1, 8'h00, 8'h09, 0, 0, 0);
        add("cnt08",      0, 0, 1, 8'h00, 8'h08, 0, 0, 0);
        add("ld3c",       0, 1, 0, 8'h3C, 8'h39, 0, 0, 1);
        add("err_clr",    0, 0, 0, 8'h00, 8'h39, 0, 0, 0);
        add("ld00",       0, 1, 0, 8'h00, 8'h00, 1, 0, 0);
        add("ld_vs_uf",   0, 1, 1, 8'h05, 8'h05, 0, 0, 0);
        add("ld20",       0, 1, 0, 8'h20, 8'h20, 0, 0, 0);
        add("cnt19",      0, 0, 1, 8'h00, 8'h19, 0, 0, 0);
        add("ldA0",       0, 1, 0, 8'hA0, 8'h90, 0, 0, 1);
        add("ldFF_en",    0, 1, 1, 8'hFF, 8'h99, 0, 0, 1);
        add("ld47",       0, 1, 0, 8'h47, 8'h47, 0, 0, 0);
        add("rst_mid",    1, 1, 1, 8'h3C, 8'h00, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].load, vecs[i].en, vecs[i].din);
            check_all(vecs[i].name, vecs[i].q, vecs[i].zero, vecs[i].borrow, vecs[i].load_err);
        end

        // Long run from 25 through zero, checked against a decimal model.
        step(0, 1, 0, 8'h25);
        check_all("run_ld", 8'h25, 0, 0, 0);
        val = 25;
        armed = 1'b1;
        for (int i = 0; i < 30; i++) begin
            exp_b = 1'b0;
            if (val == 0) begin
                if (sat) begin
                    exp_b = armed;
                    armed = 1'b0;
                end else begin
                    exp_b = 1'b1;
                    val = 99;
                end
            end else begin
                val = val - 1;
            end
            step(0, 0, 1, 8'h00);
            check_all($sformatf("run%0d", i), to_bcd(val), (val == 0), exp_b, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
